spi_master_cfg: RTL

//  Parametrised SPI master. Runtime-selectable SPI mode 0-3 (CPOL/CPHA) and bit order.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_half_tick.sv | 28 ++
 rtl/spi_master_cfg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master: FSM encoding and SPI mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_TRANSFER = 2'd2,
    ST_CS_HOLD  = 2'd3
  } spi_state_e;

  // mode word is {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV clocks, held at zero while cleared.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with runtime mode/bit-order selection, chip-select setup/hold and a
// configurable sck half-period. Handshake: start_i is accepted in any cycle busy_o=0.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              lsb_first_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              miso_i,
  output logic              sck_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_n_o,
  output logic              busy_o,
  output logic              new_data_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic [1:0]        state_o
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_q, rx_q, data_out_q;
  logic [EW-1:0]     edge_q;
  logic              sck_q, mosi_q, new_data_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic tick, accept, sck_edge, done, last_edge, odd_edge, cpha, shift_en, sample_en;

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Out-of-range selects leave every chip select deasserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) r[i] = 1'b0;
    return r;
  endfunction

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == ST_IDLE),
    .tick_o  (tick)
  );

  assign last_edge = (edge_q == LAST_EDGE);
  assign odd_edge  = ~edge_q[0];
  assign cpha      = mode_q[CPHA_BIT];
  assign shift_en  = sck_edge && (cpha ? odd_edge : (!odd_edge && !last_edge));
  assign sample_en = sck_edge && (cpha ? !odd_edge : odd_edge);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    sck_edge = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: if (tick) state_d = ST_TRANSFER;
      ST_TRANSFER: begin
        if (tick) begin
          sck_edge = 1'b1;
          if (last_edge) state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE0;
      lsb_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      edge_q     <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      new_data_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      new_data_q <= 1'b0;
      if (state_q == ST_IDLE && !accept) sck_q <= mode_q[CPOL_BIT];
      if (accept) begin
        mode_q <= mode_i;
        lsb_q  <= lsb_first_i;
        sck_q  <= mode_i[CPOL_BIT];
        cs_n_q <= cs_decode(cs_sel_i);
        rx_q   <= '0;
        edge_q <= '0;
        // CPHA=0 must present the first bit before the first sck edge.
        if (!mode_i[CPHA_BIT]) begin
          mosi_q <= head_bit(data_in_i, lsb_first_i);
          tx_q   <= shift_out(data_in_i, lsb_first_i);
        end else begin
          tx_q   <= data_in_i;
        end
      end
      if (sck_edge) begin
        sck_q  <= ~sck_q;
        edge_q <= last_edge ? '0 : edge_q + 1'b1;
      end
      if (shift_en) begin
        mosi_q <= head_bit(tx_q, lsb_q);
        tx_q   <= shift_out(tx_q, lsb_q);
      end
      if (sample_en)
        rx_q <= lsb_q ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
      if (done) begin
        cs_n_q     <= '1;
        data_out_q <= rx_q;
        new_data_q <= 1'b1;
      end
    end
  end

  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign new_data_o = new_data_q;
  assign data_out_o = data_out_q;
  assign state_o    = state_q;

endmodule
